// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state enum, BCD digit type, digit-adjust constants and counter sizing.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    // Width of a down-counter that must hold W_BIN-1; never narrower than one bit.
    function automatic int cnt_width(input int w_bin);
        return (w_bin <= 2) ? 1 : $clog2(w_bin);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bus between a binary source, the BCD converter and the display driver.
// Optional BCD_BLANK_LEADING_ZERO_EN adds the blank_mask result signal.
interface bin_to_bcd_seq_if #(
    parameter int W_BIN    = 8,
    parameter int N_DIGITS = 3
);
    logic                    in_valid;
    logic                    in_ready;
    logic [W_BIN-1:0]        bin_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [4*N_DIGITS-1:0]   bcd_out;
    logic                    overflow;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic [N_DIGITS-1:0]     blank_mask;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, overflow, blank_mask
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, overflow, blank_mask
    );
`else
    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, overflow
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, overflow
    );
`endif

endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble cell: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);

    always_comb begin
        d_out = d_in;
        if (d_in >= BCD_ADJ_THRESH) begin
            d_out = d_in + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional macro BCD_BLANK_LEADING_ZERO_EN adds the registered leading-zero blank_mask.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an input handshake
// SHIFT | one adjust+shift per cycle, W_BIN cycles total
// DONE  | out_valid=1, result held until out_ready
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int W_BIN    = 8,
    parameter int N_DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus
);

    localparam int              CW       = cnt_width(W_BIN);
    localparam int              AW       = 4 * N_DIGITS;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(W_BIN - 1);

    bcd_state_t         state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [W_BIN-1:0]   sr_q, sr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [AW-1:0]      bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [AW-1:0]      acc_adj;
    logic [AW-1:0]      acc_shift;
    logic               carry_out;

    // One adjust column, reused every SHIFT cycle.
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (acc_q[4*g +: 4]),
            .d_out (acc_adj[4*g +: 4])
        );
    end

    // The bit leaving the top digit means the value needs more digits than we have.
    assign {carry_out, acc_shift} = {acc_adj, sr_q[W_BIN-1]};

`ifdef BCD_BLANK_LEADING_ZERO_EN
    logic [N_DIGITS-1:0] mask_q, mask_d;
    logic [N_DIGITS-1:0] mask_calc;
    logic                zero_above;

    // Digit 0 is never blanked so a zero value still shows one "0".
    always_comb begin
        mask_calc  = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above & (acc_shift[4*i +: 4] == 4'd0);
            mask_calc[i] = zero_above;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
`ifdef BCD_BLANK_LEADING_ZERO_EN
        mask_d    = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sr_d      = bus.bin_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                acc_d     = acc_shift;
                sr_d      = sr_q << 1;
                ovf_acc_d = ovf_acc_q | carry_out;
                if (cnt_q == '0) begin
                    // Output register only changes here, so the display never sees partial sums.
                    state_d = DONE;
                    bcd_d   = acc_shift;
                    ovf_d   = ovf_acc_q | carry_out;
`ifdef BCD_BLANK_LEADING_ZERO_EN
                    mask_d  = mask_calc;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
`ifdef BCD_BLANK_LEADING_ZERO_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
`ifdef BCD_BLANK_LEADING_ZERO_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = ovf_q;
`ifdef BCD_BLANK_LEADING_ZERO_EN
    assign bus.blank_mask = mask_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and swept checks of bin_to_bcd_seq in four width/digit configurations.
// Honours BCD_BLANK_LEADING_ZERO_EN when the bundle is built with it.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.W_BIN(8),  .N_DIGITS(3)) i0 ();
    bin_to_bcd_seq_if #(.W_BIN(8),  .N_DIGITS(2)) i1 ();
    bin_to_bcd_seq_if #(.W_BIN(16), .N_DIGITS(5)) i2 ();
    bin_to_bcd_seq_if #(.W_BIN(16), .N_DIGITS(4)) i3 ();

    bin_to_bcd_seq #(.W_BIN(8),  .N_DIGITS(3)) u0 (.clk(clk), .rst(rst), .bus(i0));
    bin_to_bcd_seq #(.W_BIN(8),  .N_DIGITS(2)) u1 (.clk(clk), .rst(rst), .bus(i1));
    bin_to_bcd_seq #(.W_BIN(16), .N_DIGITS(5)) u2 (.clk(clk), .rst(rst), .bus(i2));
    bin_to_bcd_seq #(.W_BIN(16), .N_DIGITS(4)) u3 (.clk(clk), .rst(rst), .bus(i3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] b, input logic r);
        case (sel)
            0:       begin i0.in_valid = v; i0.bin_in = b[7:0];  i0.out_ready = r; end
            1:       begin i1.in_valid = v; i1.bin_in = b[7:0];  i1.out_ready = r; end
            2:       begin i2.in_valid = v; i2.bin_in = b[15:0]; i2.out_ready = r; end
            default: begin i3.in_valid = v; i3.bin_in = b[15:0]; i3.out_ready = r; end
        endcase
    endtask

    task automatic rd(input int sel, output logic ir, output logic ov,
                      output logic [39:0] bcd, output logic ovf, output logic [9:0] mask);
        mask = '0;
        case (sel)
            0: begin ir = i0.in_ready; ov = i0.out_valid; bcd = 40'(i0.bcd_out); ovf = i0.overflow;
`ifdef BCD_BLANK_LEADING_ZERO_EN
                mask = 10'(i0.blank_mask);
`endif
            end
            1: begin ir = i1.in_ready; ov = i1.out_valid; bcd = 40'(i1.bcd_out); ovf = i1.overflow; end
            2: begin ir = i2.in_ready; ov = i2.out_valid; bcd = 40'(i2.bcd_out); ovf = i2.overflow; end
            default: begin ir = i3.in_ready; ov = i3.out_valid; bcd = 40'(i3.bcd_out); ovf = i3.overflow; end
        endcase
    endtask

    function automatic logic [39:0] to_bcd(input longint v, input int nd);
        logic [39:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Full conversion from IDLE: handshake, exact latency, result capture, out handshake.
    task automatic convert(input int sel, input logic [31:0] val, input int w,
                           output logic [39:0] bcd, output logic ovf, output logic [9:0] mask);
        logic ir, ov;
        int   lat;
        rd(sel, ir, ov, bcd, ovf, mask);
        chk("in_ready_idle", 64'(ir), 64'd1);
        drive(sel, 1'b1, val, 1'b0);
        @(posedge clk); #1;
        drive(sel, 1'b0, 32'd0, 1'b0);
        rd(sel, ir, ov, bcd, ovf, mask);
        chk("in_ready_shift", 64'(ir), 64'd0);
        lat = 0;
        while (!ov && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            rd(sel, ir, ov, bcd, ovf, mask);
        end
        chk("latency", 64'(lat), 64'(w));
        drive(sel, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 32'd0, 1'b0);
    endtask

    logic [39:0] b;
    logic        o, ir, ov;
    logic [9:0]  m;
    logic [31:0] v;
    logic [31:0] edges5 [4];
    int          n;

    initial begin
        edges5[0] = 32'd0;
        edges5[1] = 32'd65535;
        edges5[2] = 32'd9999;
        edges5[3] = 32'd10000;
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        rd(0, ir, ov, b, o, m);
        chk("rst_in_ready", 64'(ir), 64'd1);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_bcd", 64'(b), 64'd0);
        chk("rst_ovf", 64'(o), 64'd0);
        chk("rst_mask", 64'(m), 64'd0);

        convert(0, 32'd173, 8, b, o, m);
        chk("v173_bcd", 64'(b), 64'h173);
        chk("v173_ovf", 64'(o), 64'd0);

        convert(0, 32'd0, 8, b, o, m);
        chk("v0_bcd", 64'(b), 64'h000);
        chk("v0_ovf", 64'(o), 64'd0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        chk("v0_mask", 64'(m), 64'b110);
`endif
        convert(0, 32'd255, 8, b, o, m);
        chk("v255_bcd", 64'(b), 64'h255);
        chk("v255_ovf", 64'(o), 64'd0);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        chk("v255_mask", 64'(m), 64'b000);
`endif

        convert(1, 32'd100, 8, b, o, m);
        chk("n2_v100_bcd", 64'(b), 64'h00);
        chk("n2_v100_ovf", 64'(o), 64'd1);
        convert(1, 32'd255, 8, b, o, m);
        chk("n2_v255_bcd", 64'(b), 64'h55);
        chk("n2_v255_ovf", 64'(o), 64'd1);
        convert(1, 32'd99, 8, b, o, m);
        chk("n2_v99_bcd", 64'(b), 64'h99);
        chk("n2_v99_ovf", 64'(o), 64'd0);

        // Back-to-back: 7 is presented while 42 is still converting and being held.
        drive(0, 1'b1, 32'd42, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd7, 1'b0);
        n = 0;
        rd(0, ir, ov, b, o, m);
        while (!ov && n < 100) begin
            @(posedge clk); #1;
            n++;
            rd(0, ir, ov, b, o, m);
        end
        chk("b2b_latency", 64'(n), 64'd8);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            rd(0, ir, ov, b, o, m);
            chk("hold_bcd", 64'(b), 64'h042);
            chk("hold_in_ready", 64'(ir), 64'd0);
            chk("hold_out_valid", 64'(ov), 64'd1);
        end
        drive(0, 1'b1, 32'd7, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b1, 32'd7, 1'b0);
        rd(0, ir, ov, b, o, m);
        chk("after_hs_in_ready", 64'(ir), 64'd1);
        chk("after_hs_out_valid", 64'(ov), 64'd0);
        chk("after_hs_bcd_kept", 64'(b), 64'h042);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 1'b0);
        rd(0, ir, ov, b, o, m);
        chk("v7_accepted", 64'(ir), 64'd0);
        chk("v7_shift_bcd_kept", 64'(b), 64'h042);
        n = 0;
        while (!ov && n < 100) begin
            @(posedge clk); #1;
            n++;
            rd(0, ir, ov, b, o, m);
        end
        chk("v7_latency", 64'(n), 64'd8);
        chk("v7_bcd", 64'(b), 64'h007);
`ifdef BCD_BLANK_LEADING_ZERO_EN
        chk("v7_mask", 64'(m), 64'b110);
`endif
        drive(0, 1'b0, 32'd0, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 1'b0);

        // Reset sampled at the end of the 4th SHIFT cycle of 200.
        drive(0, 1'b1, 32'd200, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(0, ir, ov, b, o, m);
        chk("abort_in_ready", 64'(ir), 64'd1);
        chk("abort_out_valid", 64'(ov), 64'd0);
        chk("abort_bcd", 64'(b), 64'd0);
        repeat (10) begin @(posedge clk); #1; end
        rd(0, ir, ov, b, o, m);
        chk("abort_no_valid", 64'(ov), 64'd0);
        convert(0, 32'd59, 8, b, o, m);
        chk("v59_bcd", 64'(b), 64'h059);
        chk("v59_ovf", 64'(o), 64'd0);

        for (int k = 0; k < 1000; k++) begin
            v = (k < 4) ? edges5[k] : 32'($urandom_range(0, 65535));
            convert(2, v, 16, b, o, m);
            chk("sweep5_bcd", 64'(b), 64'(to_bcd(longint'(v), 5)));
            chk("sweep5_ovf", 64'(o), 64'd0);
        end

        for (int k = 0; k < 200; k++) begin
            v = (k < 4) ? edges5[k] : 32'($urandom_range(0, 65535));
            convert(3, v, 16, b, o, m);
            chk("sweep4_bcd", 64'(b), 64'(to_bcd(longint'(v) % 10000, 4)));
            chk("sweep4_ovf", 64'(o), 64'(v >= 32'd10000));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
